// File: rtl/frame_gen_param.sv
// Light-cube frame generator: voxel/column/layer/fill patterns stepped by a prescaler; FRAME_GEN_BOUNCE_EN makes layer mode ping-pong.
// Latency: a frame registers one cycle after its step fires, and a new frame can load every cycle.
// Backpressure: valid/ready; an unaccepted frame holds steady and the next step waits, so no frame is dropped.
module frame_gen_param #(
    parameter  int N     = 8,
    parameter  int DIV_W = 16,
    localparam int IDX_W = $clog2(N*N*N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic [DIV_W-1:0]   i_step_div,
    input  logic               i_frame_ready,
    output logic               o_frame_valid,
    output logic [N*N*N-1:0]   o_frame_data,
    output logic [IDX_W-1:0]   o_frame_idx
);
    localparam int VOX  = N*N*N;
    localparam int COLS = N*N;

    logic [DIV_W-1:0] r_div_cnt;
    logic [IDX_W-1:0] r_pos;
    logic [1:0]       r_mode_q;
    logic             r_frame_valid;
    logic [VOX-1:0]   r_frame_data;
    logic [IDX_W-1:0] r_frame_idx;

    logic             w_div_hit;
    logic             w_step;
    logic             w_mode_chg;
    logic [IDX_W-1:0] w_p;
    logic [IDX_W-1:0] w_pos_nxt;
    logic [VOX-1:0]   w_pattern;

    // >= rather than == so a step_div lowered below the running count cannot lock the prescaler
    assign w_div_hit  = (r_div_cnt >= i_step_div);
    assign w_step     = i_en && w_div_hit && (!r_frame_valid || i_frame_ready);
    assign w_mode_chg = (i_mode != r_mode_q);
    assign w_p        = w_mode_chg ? '0 : r_pos;

`ifdef FRAME_GEN_BOUNCE_EN
    logic r_dir;
    logic w_dir_eff;
    logic w_dir_nxt;
    assign w_dir_eff = w_mode_chg || r_dir;
`endif

    always_comb begin
        w_pattern = '0;
        for (int col = 0; col < COLS; col++) begin
            for (int z = 0; z < N; z++) begin
                case (i_mode)
                    2'd0:    w_pattern[col*N+z] = (IDX_W'(col*N+z) == w_p);
                    2'd1:    w_pattern[col*N+z] = (IDX_W'(col) == w_p);
                    2'd2:    w_pattern[col*N+z] = (IDX_W'(z) == w_p);
                    default: w_pattern[col*N+z] = (IDX_W'(col) < w_p);
                endcase
            end
        end
    end

    always_comb begin
        w_pos_nxt = w_p + IDX_W'(1);
`ifdef FRAME_GEN_BOUNCE_EN
        w_dir_nxt = w_dir_eff;
`endif
        case (i_mode)
            2'd0: if (w_p == IDX_W'(VOX-1))  w_pos_nxt = '0;
            2'd1: if (w_p == IDX_W'(COLS-1)) w_pos_nxt = '0;
            2'd2: begin
`ifdef FRAME_GEN_BOUNCE_EN
                if (w_dir_eff) begin
                    if (w_p == IDX_W'(N-1)) begin
                        w_pos_nxt = w_p - IDX_W'(1);
                        w_dir_nxt = 1'b0;
                    end
                end else if (w_p == '0) begin
                    w_dir_nxt = 1'b1;
                end else begin
                    w_pos_nxt = w_p - IDX_W'(1);
                end
`else
                if (w_p == IDX_W'(N-1)) w_pos_nxt = '0;
`endif
            end
            default: if (w_p == IDX_W'(COLS)) w_pos_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_cnt     <= '0;
            r_pos         <= '0;
            r_mode_q      <= 2'd0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_idx   <= '0;
`ifdef FRAME_GEN_BOUNCE_EN
            r_dir         <= 1'b1;
`endif
        end else begin
            if (w_step)
                r_div_cnt <= '0;
            else if (i_en && !w_div_hit)
                r_div_cnt <= r_div_cnt + DIV_W'(1);

            if (w_step) begin
                r_frame_valid <= 1'b1;
                r_frame_data  <= w_pattern;
                r_frame_idx   <= w_p;
                r_mode_q      <= i_mode;
                r_pos         <= w_pos_nxt;
`ifdef FRAME_GEN_BOUNCE_EN
                r_dir         <= w_dir_nxt;
`endif
            end else if (r_frame_valid && i_frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign o_frame_valid = r_frame_valid;
    assign o_frame_data  = r_frame_data;
    assign o_frame_idx   = r_frame_idx;
endmodule

// File: tb/tb_frame_gen_param.sv
// Directed bench for frame_gen_param (N=8): scan, prescaler, stall, fill, layer, mode switch and reset.
module tb_frame_gen_param;
    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [15:0]  step_div;
    logic         ready;
    logic         valid;
    logic [511:0] data;
    logic [8:0]   idx;

    int n_chk = 0;
    int n_err = 0;

    frame_gen_param #(.N(8), .DIV_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_mode        (mode),
        .i_step_div    (step_div),
        .i_frame_ready (ready),
        .o_frame_valid (valid),
        .o_frame_data  (data),
        .o_frame_idx   (idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [15:0] d);
        rst   = 1'b0;
        en    = 1'b0;
        ready = 1'b1;
        tick();
        mode     = m;
        step_div = d;
        rst      = 1'b1;
        en       = 1'b1;
    endtask

    function automatic logic [511:0] col_pat(input int p);
        logic [511:0] e;
        e = '0;
        e[p*8 +: 8] = 8'hFF;
        return e;
    endfunction

    function automatic logic [511:0] layer_pat(input int p);
        logic [511:0] e;
        e = '0;
        for (int c = 0; c < 64; c++) e[c*8 + p] = 1'b1;
        return e;
    endfunction

    initial begin
        logic [511:0] e;
        int exp_p;

        rst = 1'b0; en = 1'b0; mode = 2'd0; step_div = 16'd0; ready = 1'b1;
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_idx", idx, 0);

        // voxel scan, one frame per cycle, full wrap
        do_reset(2'd0, 16'd0);
        for (int k = 0; k <= 512; k++) begin
            tick();
            e = '0;
            e[k % 512] = 1'b1;
            chk("vox_valid", valid, 1);
            chk("vox_idx", idx, k % 512);
            chk("vox_data", data, e);
        end

        // prescaler divide by 4
        do_reset(2'd0, 16'd3);
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("div_valid", valid, (t % 4 == 0));
            if (t % 4 == 0) chk("div_idx", idx, t / 4 - 1);
        end

        // enable freeze
        do_reset(2'd0, 16'd0);
        for (int k = 0; k < 3; k++) tick();
        chk("en_idx2", idx, 2);
        en = 1'b0;
        tick();
        chk("en_off_valid0", valid, 0);
        tick();
        chk("en_off_valid1", valid, 0);
        en = 1'b1;
        tick();
        chk("en_resume_idx", idx, 3);
        chk("en_resume_valid", valid, 1);

        // column scan with 10-cycle stall at idx 5
        do_reset(2'd1, 16'd0);
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk("col_idx", idx, k);
        end
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_valid", valid, 1);
            chk("stall_idx", idx, 5);
            chk("stall_data", data, col_pat(5));
        end
        ready = 1'b1;
        tick();
        chk("unstall_idx6", idx, 6);
        chk("unstall_data6", data, col_pat(6));
        tick();
        chk("unstall_idx7", idx, 7);

        // column fill
        do_reset(2'd3, 16'd0);
        for (int k = 0; k <= 65; k++) begin
            tick();
            chk("fill_idx", idx, k % 65);
            if (k == 0)  chk("fill_blank0", data, 0);
            if (k == 1)  chk("fill_one", data, 512'hFF);
            if (k == 64) chk("fill_full", data, {512{1'b1}});
            if (k == 65) chk("fill_blank_wrap", data, 0);
        end

        // layer sweep, 20 steps
        do_reset(2'd2, 16'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
`ifdef FRAME_GEN_BOUNCE_EN
            exp_p = (k % 14 < 8) ? (k % 14) : (14 - k % 14);
`else
            exp_p = k % 8;
`endif
            chk("layer_idx", idx, exp_p);
            chk("layer_data", data, layer_pat(exp_p));
        end

        // mode switch 0 -> 2 at idx 9, then reset during a stall
        do_reset(2'd0, 16'd0);
        for (int k = 0; k <= 9; k++) tick();
        chk("sw_idx9", idx, 9);
        mode = 2'd2;
        tick();
        chk("sw_layer_idx0", idx, 0);
        chk("sw_layer_data0", data, layer_pat(0));
        tick();
        chk("sw_layer_idx1", idx, 1);
        ready = 1'b0;
        tick();
        chk("sw_stall_idx", idx, 1);
        chk("sw_stall_valid", valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_idx", idx, 0);
        tick();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
